gmii_rx_filter: RTL and testbench
=================================

Name: gmii_rx_filter

Overview:
Receive-side GMII front end on rx_clk, placed directly between the PHY GMII receive pins and the packet FIFO's rx_data/rx_dv/rx_er inputs. It strips and validates preamble/SFD and forwards only frame bytes (DA through FCS) as a contiguous rx_dv burst. Bad frames are marked by asserting rx_er on their final byte, so downstream keeps frame delimiting purely on rx_dv. Good and bad frames are counted.

Parameters:
MIN_PREAMBLE, 1, minimum number of 0x55 bytes required before SFD (0xD5)
MIN_LEN, 64, minimum frame length in bytes (incl. FCS); shorter frames are marked bad
MAX_LEN, 1522, maximum frame length; frames are truncated at this length and marked bad (legal range 1..16383)

Ports:
rst  in  1  asynchronous, active-high reset
rx_clk  in  1  GMII receive clock; all logic is on this clock
gmii_rxd  in  8  PHY receive data
gmii_rx_dv  in  1  PHY receive data valid
gmii_rx_er  in  1  PHY receive error
rx_data  out  8  frame byte to packet FIFO
rx_dv  out  1  high for every forwarded frame byte; the falling edge marks end of frame
rx_er  out  1  per-byte error; always high on the last byte of a bad frame
frame_cnt  out  16  good-frame counter, wraps
err_cnt  out  16  bad-frame / preamble-error counter, wraps

Behaviour:
- Reset (rst high, asynchronous): rx_dv=0, rx_er=0, rx_data=0, frame_cnt=0, err_cnt=0, state=DROP, length counter=0.
- Reset mid-frame: outputs drop to 0 immediately. After release, the block stays in DROP until gmii_rx_dv is sampled low, so no partial frame is ever forwarded.
- Input stage: gmii_* is registered once (s1). The output is registered from s1, and its rx_dv/rx_er are computed using the current input. Latency is exactly 2 rx_clk cycles from input sample to output.
- State IDLE:
  - gmii_rx_dv=1 with rxd=0x55 → PRE, preamble count=1.
  - gmii_rx_dv=1 with any other byte → DROP, err_cnt+1.
  - gmii_rx_dv=0 with gmii_rx_er=1 (false carrier / carrier extend) is ignored.
- State PRE:
  - 0x55 → count increments, saturating at 15.
  - 0xD5 with count≥MIN_PREAMBLE → DATA, length=0.
  - 0xD5 with short preamble, any other byte, gmii_rx_er=1, or dv low → err_cnt+1. Go to IDLE if dv is low, else DROP.
- State DATA:
  - Each input byte with dv=1 is forwarded, and length increments (14-bit).
  - gmii_rx_er=1 on a byte passes through as rx_er on that byte and sets a sticky bad flag.
  - End of frame (input dv=0):
    - The held last byte is output with rx_dv=1.
    - rx_er=1 if sticky bad or length<MIN_LEN.
    - If bad, err_cnt+1; otherwise frame_cnt+1.
    - Next cycle rx_dv=0; state → IDLE.
  - Truncation: if length==MAX_LEN and the input still has dv=1, byte MAX_LEN is output as the last byte with rx_er=1. err_cnt+1, state → DROP.
  - Zero-length frame (SFD then dv low): nothing is output, err_cnt+1.
- State DROP: outputs stay idle (rx_dv=0, rx_er=0); go to IDLE when gmii_rx_dv=0.
- Output framing:
  - rx_dv is contiguous within a frame.
  - At least 1 idle cycle separates frames, because the SFD is consumed and preamble bytes are never forwarded.
  - rx_data is don't-care when rx_dv=0 but is driven 0.
- Counters update in the same cycle as the last-byte output. Each frame increments exactly one counter, and 0xFFFF wraps to 0.

Test Plan:
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, dv low → rx_dv high 64 cycles starting 2 cycles after the first data byte; data 0x00..0x3F; rx_er=0 throughout; frame_cnt=1, err_cnt=0.
- Same preamble, 60-byte frame → 60 bytes out with rx_er=1 only on byte 60; err_cnt=1.
- 1600-byte frame with MAX_LEN=1522 → exactly 1522 bytes out; rx_er=1 on byte 1522; rx_dv low for the remaining 78 input bytes; err_cnt=1; the next good frame is forwarded normally.
- gmii_rx_er pulsed on byte 10 of a 100-byte frame → rx_er=1 on output bytes 10 and 100; err_cnt=1.
- Preamble error and reset cases:
  - 0x55, 0x12, data… → no output, err_cnt=1.
  - dv=0 with rx_er=1 and rxd=0x0F → no output, no count change.
- Assert rst during byte 30 of a frame and release while dv is still high → rx_dv=0 immediately; counters=0; no output until dv low; the following frame gives frame_cnt=1.

Source files
------------

// File: rtl/gmii_rx_filter.sv
// GMII receive front end: strips and validates preamble/SFD, forwards frame bytes
// as a contiguous rx_dv burst, flags bad frames on their last byte and counts frames.
module gmii_rx_filter #(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1522
) (
    input  logic        rst,
    input  logic        rx_clk,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_dv,
    output logic        rx_er,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);

    state_t      r_state;
    state_t      w_stateNext;

    logic [7:0]  r_s1Data;
    logic        r_s1Er;

    logic [13:0] r_len;
    logic [13:0] w_lenNext;
    logic [3:0]  r_preCnt;
    logic [3:0]  w_preCntNext;
    logic        r_sticky;
    logic        w_stickyNext;

    logic [7:0]  r_rxData;
    logic [7:0]  w_dataNext;
    logic        r_rxDv;
    logic        w_dvNext;
    logic        r_rxEr;
    logic        w_erNext;

    logic [15:0] r_frameCnt;
    logic [15:0] r_errCnt;
    logic        w_goodInc;
    logic        w_badInc;

    logic        w_preOk;
    logic        w_lastBad;
    logic        w_preByte;
    logic        w_sfdByte;

    assign w_preOk   = 32'(r_preCnt) >= MIN_PREAMBLE;
    assign w_lastBad = r_sticky | (32'(r_len) < MIN_LEN);
    assign w_preByte = gmii_rx_dv && !gmii_rx_er && (gmii_rxd == PRE_BYTE);
    assign w_sfdByte = gmii_rx_dv && !gmii_rx_er && (gmii_rxd == SFD_BYTE);

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_state <= DROP;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The held byte in s1 is only known to be last once the live input shows dv low,
    // so every decision below looks at the current gmii input and emits s1.
    always_comb begin
        w_stateNext  = r_state;
        w_lenNext    = r_len;
        w_preCntNext = r_preCnt;
        w_stickyNext = r_sticky;
        w_dataNext   = 8'h00;
        w_dvNext     = 1'b0;
        w_erNext     = 1'b0;
        w_goodInc    = 1'b0;
        w_badInc     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        w_stateNext  = PRE;
                        w_preCntNext = 4'd1;
                    end else begin
                        w_stateNext = DROP;
                        w_badInc    = 1'b1;
                    end
                end
            end

            PRE: begin
                if (w_preByte) begin
                    if (r_preCnt != 4'hF) begin
                        w_preCntNext = r_preCnt + 4'd1;
                    end
                end else if (w_sfdByte && w_preOk) begin
                    w_stateNext  = DATA;
                    w_lenNext    = 14'd0;
                    w_stickyNext = 1'b0;
                end else begin
                    w_badInc    = 1'b1;
                    w_stateNext = gmii_rx_dv ? DROP : IDLE;
                end
            end

            DATA: begin
                if (gmii_rx_dv && (r_len == MAX_LEN_W)) begin
                    w_dataNext  = r_s1Data;
                    w_dvNext    = 1'b1;
                    w_erNext    = 1'b1;
                    w_badInc    = 1'b1;
                    w_stateNext = DROP;
                end else if (gmii_rx_dv) begin
                    // s1 still holds the SFD on the first data byte, so nothing is emitted yet
                    if (r_len != 14'd0) begin
                        w_dataNext = r_s1Data;
                        w_dvNext   = 1'b1;
                        w_erNext   = r_s1Er;
                    end
                    w_lenNext    = r_len + 14'd1;
                    w_stickyNext = r_sticky | gmii_rx_er;
                end else begin
                    w_stateNext = IDLE;
                    if (r_len == 14'd0) begin
                        w_badInc = 1'b1;
                    end else begin
                        w_dataNext = r_s1Data;
                        w_dvNext   = 1'b1;
                        w_erNext   = w_lastBad;
                        w_badInc   = w_lastBad;
                        w_goodInc  = !w_lastBad;
                    end
                end
            end

            DROP: begin
                if (!gmii_rx_dv) begin
                    w_stateNext = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_s1Data   <= 8'h00;
            r_s1Er     <= 1'b0;
            r_len      <= 14'd0;
            r_preCnt   <= 4'd0;
            r_sticky   <= 1'b0;
            r_rxData   <= 8'h00;
            r_rxDv     <= 1'b0;
            r_rxEr     <= 1'b0;
            r_frameCnt <= 16'd0;
            r_errCnt   <= 16'd0;
        end else begin
            r_s1Data <= gmii_rxd;
            r_s1Er   <= gmii_rx_er;
            r_len    <= w_lenNext;
            r_preCnt <= w_preCntNext;
            r_sticky <= w_stickyNext;
            r_rxData <= w_dataNext;
            r_rxDv   <= w_dvNext;
            r_rxEr   <= w_erNext;
            if (w_goodInc) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
            if (w_badInc) begin
                r_errCnt <= r_errCnt + 16'd1;
            end
        end
    end

    assign rx_data   = r_rxData;
    assign rx_dv     = r_rxDv;
    assign rx_er     = r_rxEr;
    assign frame_cnt = r_frameCnt;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_gmii_rx_filter.sv
// Bench for gmii_rx_filter: directed and random GMII frames compared against a
// frame-level reference model of the forwarded byte stream and counters.
`timescale 1ns/1ps
module tb_gmii_rx_filter;

    localparam int MIN_PREAMBLE = 1;
    localparam int MIN_LEN      = 64;
    localparam int MAX_LEN      = 1522;
    localparam int PERIOD       = 10;

    logic        rst;
    logic        rxClk;
    logic [7:0]  gmiiRxd;
    logic        gmiiRxDv;
    logic        gmiiRxEr;
    logic [7:0]  rxData;
    logic        rxDv;
    logic        rxEr;
    logic [15:0] frameCnt;
    logic [15:0] errCnt;

    int          cmpCnt = 0;
    int          failCnt = 0;
    int          cyc = 0;
    int          dvRise = 0;
    int          idleBad = 0;
    int          firstCyc = -1;
    int          byte0Cyc = -1;
    logic        prevDv = 1'b0;
    logic [8:0]  outQ[$];
    logic [8:0]  expQ[$];
    logic [7:0]  payD[$];
    logic        payE[$];
    logic [15:0] expFrame = 16'd0;
    logic [15:0] expErr = 16'd0;

    gmii_rx_filter #(
        .MIN_PREAMBLE(MIN_PREAMBLE),
        .MIN_LEN     (MIN_LEN),
        .MAX_LEN     (MAX_LEN)
    ) dut (
        .rst       (rst),
        .rx_clk    (rxClk),
        .gmii_rxd  (gmiiRxd),
        .gmii_rx_dv(gmiiRxDv),
        .gmii_rx_er(gmiiRxEr),
        .rx_data   (rxData),
        .rx_dv     (rxDv),
        .rx_er     (rxEr),
        .frame_cnt (frameCnt),
        .err_cnt   (errCnt)
    );

    initial rxClk = 1'b0;
    always #(PERIOD / 2) rxClk = ~rxClk;

    always @(posedge rxClk) cyc <= cyc + 1;

    // Output monitor samples shortly after each rising edge
    always @(posedge rxClk) begin
        #2;
        if (rxDv === 1'b1) begin
            if (prevDv !== 1'b1) begin
                dvRise++;
                if (firstCyc < 0) firstCyc = cyc;
            end
            outQ.push_back({rxEr, rxData});
        end else if (rxData !== 8'h00 || rxEr !== 1'b0) begin
            idleBad++;
        end
        prevDv = rxDv;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] d);
        @(negedge rxClk);
        gmiiRxDv = dv;
        gmiiRxEr = er;
        gmiiRxd  = d;
    endtask

    task automatic buildPayload(input int n, input bit incr, input int erIdx);
        payD.delete();
        payE.delete();
        for (int i = 0; i < n; i++) begin
            payD.push_back(incr ? 8'(i) : 8'($urandom));
            payE.push_back(1'(i == erIdx));
        end
    endtask

    // Reference model: frame in, expected forwarded bytes and counter update out
    task automatic modelFrame(input int nPre, input logic [7:0] sfd);
        int   n;
        int   outN;
        logic bad;
        expQ.delete();
        n = payD.size();
        if (nPre < MIN_PREAMBLE || nPre < 1 || sfd != 8'hD5 || n == 0) begin
            expErr++;
        end else begin
            outN = (n > MAX_LEN) ? MAX_LEN : n;
            bad  = (n > MAX_LEN) || (n < MIN_LEN);
            for (int i = 0; i < outN; i++) bad = bad | payE[i];
            for (int i = 0; i < outN; i++)
                expQ.push_back({(i == outN - 1) ? bad : payE[i], payD[i]});
            if (bad) expErr++;
            else expFrame++;
        end
    endtask

    task automatic clearMonitor();
        outQ.delete();
        dvRise   = 0;
        idleBad  = 0;
        firstCyc = -1;
        byte0Cyc = -1;
    endtask

    task automatic checkFrame(input string tag);
        int n;
        checkOutput({tag, ".len"}, outQ.size(), expQ.size());
        n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.byte%0d", tag, i + 1), 32'(outQ[i]), 32'(expQ[i]));
        checkOutput({tag, ".bursts"}, dvRise, (expQ.size() > 0) ? 1 : 0);
        checkOutput({tag, ".idle"}, idleBad, 0);
        if (expQ.size() > 0) checkOutput({tag, ".latency"}, firstCyc - byte0Cyc, 2);
        checkOutput({tag, ".frame_cnt"}, frameCnt, expFrame);
        checkOutput({tag, ".err_cnt"}, errCnt, expErr);
    endtask

    task automatic runFrame(input string tag, input int nPre, input logic [7:0] sfd);
        clearMonitor();
        modelFrame(nPre, sfd);
        for (int i = 0; i < nPre; i++) applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, sfd);
        for (int i = 0; i < payD.size(); i++) begin
            applyStimulus(1'b1, payE[i], payD[i]);
            if (i == 0) byte0Cyc = cyc;
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge rxClk);
        checkFrame(tag);
    endtask

    initial begin
        int nPre;
        int n;
        int erIdx;
        logic [7:0] sfd;

        rst      = 1'b1;
        gmiiRxd  = 8'h00;
        gmiiRxDv = 1'b0;
        gmiiRxEr = 1'b0;
        repeat (3) @(negedge rxClk);
        checkOutput("reset.rx_dv", rxDv, 0);
        checkOutput("reset.rx_er", rxEr, 0);
        checkOutput("reset.rx_data", rxData, 0);
        checkOutput("reset.frame_cnt", frameCnt, 0);
        checkOutput("reset.err_cnt", errCnt, 0);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        buildPayload(64, 1'b1, -1);
        runFrame("good64", 7, 8'hD5);

        buildPayload(60, 1'b0, -1);
        runFrame("short60", 7, 8'hD5);

        buildPayload(63, 1'b0, -1);
        runFrame("short63", 7, 8'hD5);

        buildPayload(1600, 1'b0, -1);
        runFrame("trunc1600", 7, 8'hD5);

        buildPayload(64, 1'b0, -1);
        runFrame("afterTrunc", 7, 8'hD5);

        buildPayload(MAX_LEN, 1'b0, -1);
        runFrame("exactMax", 7, 8'hD5);

        buildPayload(MAX_LEN + 1, 1'b0, -1);
        runFrame("maxPlus1", 7, 8'hD5);

        buildPayload(100, 1'b0, 9);
        runFrame("rxEr10", 7, 8'hD5);

        buildPayload(20, 1'b0, -1);
        runFrame("preErr", 1, 8'h12);

        buildPayload(0, 1'b0, -1);
        runFrame("zeroLen", 7, 8'hD5);

        buildPayload(1, 1'b0, -1);
        runFrame("oneByte", 1, 8'hD5);

        // False carrier while idle must be invisible
        clearMonitor();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h0F);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge rxClk);
        checkOutput("falseCarrier.len", outQ.size(), 0);
        checkOutput("falseCarrier.frame_cnt", frameCnt, expFrame);
        checkOutput("falseCarrier.err_cnt", errCnt, expErr);

        // Reset asserted on byte 30 and released while the frame is still running
        buildPayload(80, 1'b1, -1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 29; i++) applyStimulus(1'b1, 1'b0, payD[i]);
        @(negedge rxClk);
        gmiiRxd = payD[29];
        rst     = 1'b1;
        #1;
        checkOutput("midRst.rx_dv", rxDv, 0);
        checkOutput("midRst.frame_cnt", frameCnt, 0);
        checkOutput("midRst.err_cnt", errCnt, 0);
        expFrame = 16'd0;
        expErr   = 16'd0;
        for (int i = 30; i < 32; i++) applyStimulus(1'b1, 1'b0, payD[i]);
        @(negedge rxClk);
        gmiiRxd = payD[32];
        rst     = 1'b0;
        clearMonitor();
        for (int i = 33; i < 80; i++) applyStimulus(1'b1, 1'b0, payD[i]);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge rxClk);
        checkOutput("midRst.noOutput", outQ.size(), 0);
        checkOutput("midRst.idle", idleBad, 0);
        checkOutput("midRst.err_after", errCnt, 0);

        buildPayload(70, 1'b0, -1);
        runFrame("afterRst", 7, 8'hD5);

        for (int k = 0; k < 10; k++) begin
            nPre  = $urandom_range(0, 9);
            sfd   = ($urandom_range(0, 7) == 0) ? 8'h3C : 8'hD5;
            n     = $urandom_range(0, 140);
            erIdx = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            buildPayload(n, 1'b0, erIdx);
            runFrame($sformatf("rand%0d", k), nPre, sfd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
        $finish;
    end

endmodule
